memory_cell_seq: RTL

Initiator-side sequencer for the dual-port activation `memory_cell` in the LSTM forward path. For one timestep slice it:
- streams a NUM-word activation vector out of the memory's read port (B) into the datapath using valid/ready;
- concurrently accepts a NUM-word result vector from the datapath and writes it through the memory's write port (A).

It hides the memory's 1-cycle registered read latency behind a 2-entry skid buffer so that downstream backpressure never drops or duplicates a word.

---
 rtl/lstm_mem_pkg.sv | 18 +
 rtl/memory_cell_seq_if.sv | 38 +++
 rtl/rd_skid_buf.sv | 49 ++++
 rtl/memory_cell_seq.sv | 107 ++++++++++
 4 files changed

// File: rtl/lstm_mem_pkg.sv
// Shared definitions for the LSTM activation-memory sequencer: address width,
// FSM state encoding and slice base-address arithmetic.
package lstm_mem_pkg;

   localparam int ADDR_W = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   // First word address of slice t_sel when each slice holds num words.
   function automatic logic [31:0] slice_base(input logic [31:0] t_sel, input int unsigned num);
      return t_sel * num;
   endfunction

endpackage

// File: rtl/memory_cell_seq_if.sv
// Control, stream and memory-port bundle between the sequencer (master) and
// its surroundings: datapath plus memory_cell (slave).
interface memory_cell_seq_if
   import lstm_mem_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = lstm_mem_pkg::ADDR_W
);
   logic              start;
   logic [ADDR_W-1:0] t_sel;
   logic              busy;
   logic              done;
   logic              err;
   logic [WIDTH-1:0]  rd_data;
   logic              rd_valid;
   logic              rd_last;
   logic              rd_ready;
   logic [WIDTH-1:0]  wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic              mem_wr_a;
   logic [ADDR_W-1:0] mem_addr_a;
   logic [WIDTH-1:0]  mem_i_a;
   logic [ADDR_W-1:0] mem_addr_b;
   logic [WIDTH-1:0]  mem_o_b;

   modport master (
      input  start, t_sel, rd_ready, wr_data, wr_valid, mem_o_b,
      output busy, done, err, rd_data, rd_valid, rd_last, wr_ready,
             mem_wr_a, mem_addr_a, mem_i_a, mem_addr_b
   );

   modport slave (
      output start, t_sel, rd_ready, wr_data, wr_valid, mem_o_b,
      input  busy, done, err, rd_data, rd_valid, rd_last, wr_ready,
             mem_wr_a, mem_addr_a, mem_i_a, mem_addr_b
   );
endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry skid buffer for the read stream; an empty buffer passes the pushed
// word straight to the head so the memory's read latency costs no extra cycle.
module rd_skid_buf
   import lstm_mem_pkg::*;
#(
   parameter int DW = 33
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          head_valid,
   output logic [DW-1:0] head_data,
   output logic [1:0]    count
);
   logic [DW-1:0] ent0, ent1;

   assign head_valid = (count != 2'd0) || push;
   assign head_data  = (count != 2'd0) ? ent0 : (push ? push_data : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 2'd0;
         ent0  <= '0;
         ent1  <= '0;
      end else begin
         case (count)
            2'd0: if (push && !pop) begin
               ent0  <= push_data;
               count <= 2'd1;
            end
            2'd1: if (push && pop) begin
               ent0 <= push_data;
            end else if (push) begin
               ent1  <= push_data;
               count <= 2'd2;
            end else if (pop) begin
               count <= 2'd0;
            end
            // Full: the issue rule guarantees no push can arrive here.
            default: if (pop) begin
               ent0  <= ent1;
               count <= 2'd1;
            end
         endcase
      end
   end
endmodule

// File: rtl/memory_cell_seq.sv
// Slice sequencer: streams NUM words out of memory port B and stores NUM result
// words through port A, finishing with a one-cycle done pulse.
module memory_cell_seq
   import lstm_mem_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int NUM      = 53,
   parameter int TIMESTEP = 1,
   parameter int ADDR_W   = lstm_mem_pkg::ADDR_W
) (
   input logic               clk,
   input logic               rst,
   memory_cell_seq_if.master bus
);
   localparam int               CNT_W  = $clog2(NUM + 1);
   localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(NUM);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM - 1);

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  rd_cnt, wr_cnt, pop_cnt, pop_cnt_nxt, wr_cnt_nxt;
   logic              in_flight, in_flight_last;
   logic              busy_q, done_q, err_q;
   logic              run, issue, pop, wr_rdy, wr_acc, fin;
   logic              head_valid;
   logic [WIDTH:0]    head_data;
   logic [1:0]        skid_cnt;

   rd_skid_buf #(.DW(WIDTH + 1)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .push       (in_flight),
      .push_data  ({in_flight_last, bus.mem_o_b}),
      .pop        (pop),
      .head_valid (head_valid),
      .head_data  (head_data),
      .count      (skid_cnt)
   );

   assign run = (state == RUN);
   // Only issue when the word being read plus those already owed still fit.
   assign issue  = run && (rd_cnt < NUM_C) && (({1'b0, in_flight} + skid_cnt) < 2'd2);
   assign pop    = run && head_valid && bus.rd_ready;
   assign wr_rdy = run && (wr_cnt < NUM_C);
   assign wr_acc = wr_rdy && bus.wr_valid;

   assign pop_cnt_nxt = pop_cnt + CNT_W'(pop);
   assign wr_cnt_nxt  = wr_cnt + CNT_W'(wr_acc);
   assign fin         = (pop_cnt_nxt == NUM_C) && (wr_cnt_nxt == NUM_C);

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.rd_valid   = run && head_valid;
   assign bus.rd_data    = run ? head_data[WIDTH-1:0] : '0;
   assign bus.rd_last    = run && head_valid && head_data[WIDTH];
   assign bus.wr_ready   = wr_rdy;
   assign bus.mem_wr_a   = wr_acc;
   assign bus.mem_addr_a = wr_acc ? base + ADDR_W'(wr_cnt) : '0;
   assign bus.mem_i_a    = wr_acc ? bus.wr_data : '0;
   assign bus.mem_addr_b = run ? base + ADDR_W'(rd_cnt) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         base           <= '0;
         rd_cnt         <= '0;
         wr_cnt         <= '0;
         pop_cnt        <= '0;
         in_flight      <= 1'b0;
         in_flight_last <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               if (32'(bus.t_sel) < TIMESTEP) begin
                  base    <= ADDR_W'(slice_base(32'(bus.t_sel), NUM));
                  rd_cnt  <= '0;
                  wr_cnt  <= '0;
                  pop_cnt <= '0;
                  busy_q  <= 1'b1;
                  state   <= RUN;
               end else begin
                  err_q <= 1'b1;
               end
            end
            RUN: begin
               in_flight      <= issue;
               in_flight_last <= (rd_cnt == LAST_C);
               if (issue) rd_cnt <= rd_cnt + 1'b1;
               pop_cnt <= pop_cnt_nxt;
               wr_cnt  <= wr_cnt_nxt;
               if (fin) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= FINISH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
